jtag_hub_up_arbiter: RTL and testbench

JTAG_HUB_UP_ARBITER -- requirements
Module: jtag_hub_up_arbiter

---
 rtl/jtag_hub_pkg.sv | 31 +++
 rtl/jtag_hub_rr_picker.sv | 27 ++
 rtl/jtag_hub_up_arbiter.sv | 93 +++++++++
 tb/tb_jtag_hub_up_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_hub_pkg.sv
// Shared constants for the JTAG hub upstream path:
// channel IDs, channel count and output FSM encoding.
package jtag_hub_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic [3:0] ID_LA     = 4'hC;
  localparam logic [3:0] ID_IOVIEW = 4'hA;
  localparam logic [3:0] ID_GDB    = 4'h9;
  localparam logic [3:0] ID_WFG    = 4'hB;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic [3:0] ch_id(
    input logic [CH_W-1:0] idx
  );
    logic [3:0] id;
    id = ID_LA;
    unique case (idx)
      2'd0: id = ID_LA;
      2'd1: id = ID_IOVIEW;
      2'd2: id = ID_GDB;
      2'd3: id = ID_WFG;
      default: id = ID_LA;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/jtag_hub_rr_picker.sv
// Combinational 4-way round-robin select: the search
// starts just above last and wraps, so last is tried last.
module jtag_hub_rr_picker
  import jtag_hub_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic              vld,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] cand;

  always_comb begin
    vld  = 1'b0;
    idx  = last;
    cand = last;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + CH_W'(k);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/jtag_hub_up_arbiter.sv
// Upstream arbiter: four one-entry channel buffers merged
// round-robin into a single ID-tagged output register.
module jtag_hub_up_arbiter
  import jtag_hub_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [NUM_CH-1:0]          up_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] up_data,
  output logic [NUM_CH-1:0]          up_ready,
  output logic [DATA_WIDTH+3:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [NUM_CH-1:0]     full;
  logic [DATA_WIDTH-1:0] buf_q [NUM_CH];
  logic [0:0]            state;
  logic [CH_W-1:0]       last_grant;
  logic [DATA_WIDTH+3:0] out_q;

  logic                  gnt_vld;
  logic [CH_W-1:0]       gnt_idx;
  logic                  load_slot;
  logic [NUM_CH-1:0]     take;
  logic [NUM_CH-1:0]     clr;

  jtag_hub_rr_picker u_picker (
    .req  (full),
    .last (last_grant),
    .vld  (gnt_vld),
    .idx  (gnt_idx)
  );

  assign up_ready  = ~full;
  assign out_valid = (state == ST_FULL);
  assign out_data  = out_q;

  // Output register can take a word when empty or draining.
  assign load_slot = ce && ((state == ST_EMPTY) || out_ready);

  always_comb begin
    take = '0;
    clr  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      take[n] = ce && up_valid[n] && !full[n];
      clr[n]  = load_slot && gnt_vld &&
                (gnt_idx == CH_W'(n));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (take[n]) begin
          full[n] <= 1'b1;
        end else if (clr[n]) begin
          full[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++) begin
      if (take[n]) begin
        buf_q[n] <= up_data[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      out_q      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load_slot) begin
      if (gnt_vld) begin
        out_q      <= {ch_id(gnt_idx), buf_q[gnt_idx]};
        state      <= ST_FULL;
        last_grant <= gnt_idx;
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_jtag_hub_up_arbiter.sv
// Directed and scoreboarded checks for the
// JTAG hub upstream arbiter.
module tb_jtag_hub_up_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          ce;
  logic [3:0]    up_valid;
  logic [4*DW-1:0] up_data;
  logic [3:0]    up_ready;
  logic [DW+3:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int checks;
  int errors;

  logic [7:0] q [4][$];
  logic [7:0] seq [4];
  int         wait_cnt [4];

  jtag_hub_up_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_ready  (up_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] id);
    case (id)
      4'hC: return 0;
      4'hA: return 1;
      4'h9: return 2;
      4'hB: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic out_pop();
    int n;
    logic [7:0] e;
    n = idx_of(out_data[11:8]);
    chk("sb_id", 32'(n >= 0), 1);
    if (n >= 0) begin
      chk("sb_nonempty", 32'(q[n].size() > 0), 1);
      if (q[n].size() > 0) begin
        e = q[n].pop_front();
        chk("sb_order", 32'(out_data[7:0]), 32'(e));
      end
    end
  endtask

  initial begin
    logic       gpred;
    logic [3:0] fb;
    int         g;
    checks = 0;
    errors = 0;
    rst = 1'b1; ce = 1'b1; out_ready = 1'b1;
    up_valid = '0; up_data = '0;

    // reset state
    step();
    rst = 1'b0;
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_ready", 32'(up_ready), 32'hF);
    chk("rst_odata", 32'(out_data), 0);

    // single word on la
    up_valid = 4'b0001; up_data = 32'h0000_005A;
    step();
    chk("one_acc_rdy", 32'(up_ready), 32'hE);
    chk("one_acc_ov", 32'(out_valid), 0);
    up_valid = '0;
    step();
    chk("one_ov", 32'(out_valid), 1);
    chk("one_od", 32'(out_data), 32'hC5A);
    chk("one_rdy", 32'(up_ready), 32'hF);
    step();
    chk("one_drain", 32'(out_valid), 0);

    // all four at once from reset
    rst = 1'b1; step(); rst = 1'b0;
    up_valid = 4'hF; up_data = 32'h4433_2211;
    step();
    chk("all_acc_rdy", 32'(up_ready), 0);
    up_valid = '0;
    step();
    chk("all_0", 32'(out_data), 32'hC11);
    chk("all_0_rdy", 32'(up_ready), 32'h1);
    step();
    chk("all_1", 32'(out_data), 32'hA22);
    step();
    chk("all_2", 32'(out_data), 32'h933);
    step();
    chk("all_3", 32'(out_data), 32'hB44);
    chk("all_3_ov", 32'(out_valid), 1);
    step();
    chk("all_end", 32'(out_valid), 0);
    up_valid = 4'b0101; up_data = 32'h0006_0005;
    step();
    up_valid = '0;
    step();
    chk("rr_wrap_la", 32'(out_data), 32'hC05);
    step();
    chk("rr_wrap_gdb", 32'(out_data), 32'h906);
    step();
    chk("rr_wrap_end", 32'(out_valid), 0);

    // backpressure with gdb pending
    out_ready = 1'b0;
    up_valid = 4'b0100; up_data = 32'h0033_0000;
    step();
    up_valid = '0;
    step();
    chk("bp_od", 32'(out_data), 32'h933);
    chk("bp_ov", 32'(out_valid), 1);
    up_valid = 4'hF; up_data = 32'h0434_0201;
    step();
    chk("bp_full_rdy", 32'(up_ready), 0);
    up_valid = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("bp_hold", 32'({out_valid, out_data}),
          32'h1933);
    end
    chk("bp_rdy_hold", 32'(up_ready), 0);
    out_ready = 1'b1;
    step();
    chk("bp_d0", 32'(out_data), 32'hB04);
    step();
    chk("bp_d1", 32'(out_data), 32'hC01);
    step();
    chk("bp_d2", 32'(out_data), 32'hA02);
    step();
    chk("bp_d3", 32'(out_data), 32'h934);
    step();
    chk("bp_end", 32'(out_valid), 0);

    // ce toggling during a burst
    rst = 1'b1; step(); rst = 1'b0;
    up_valid = 4'hF; up_data = 32'h8877_6655;
    step();
    up_valid = '0;
    ce = 1'b0;
    step();
    chk("ce_idle", 32'(out_valid), 0);
    ce = 1'b1; step();
    chk("ce_0", 32'(out_data), 32'hC55);
    up_valid = 4'h1; up_data = 32'h0000_00EE;
    ce = 1'b0; step();
    chk("ce_0h", 32'({out_valid, out_data}), 32'h1C55);
    chk("ce_0h_rdy", 32'(up_ready), 32'h1);
    up_valid = '0;
    ce = 1'b1; step();
    chk("ce_1", 32'(out_data), 32'hA66);
    ce = 1'b0; step();
    chk("ce_1h", 32'(out_data), 32'hA66);
    ce = 1'b1; step();
    chk("ce_2", 32'(out_data), 32'h977);
    ce = 1'b0; step();
    chk("ce_2h", 32'(out_data), 32'h977);
    ce = 1'b1; step();
    chk("ce_3", 32'(out_data), 32'hB88);
    ce = 1'b0; step();
    chk("ce_3h", 32'({out_valid, out_data}), 32'h1B88);
    ce = 1'b1; step();
    chk("ce_end", 32'(out_valid), 0);

    // reset with everything full
    out_ready = 1'b0;
    up_valid = 4'hF; up_data = 32'h4433_2211;
    step();
    up_valid = '0;
    step();
    up_valid = 4'hF;
    step();
    up_valid = '0;
    chk("rf_rdy", 32'(up_ready), 0);
    chk("rf_ov", 32'(out_valid), 1);
    rst = 1'b1; ce = 1'b0;
    step();
    chk("rf_ov0", 32'(out_valid), 0);
    chk("rf_rdyF", 32'(up_ready), 32'hF);
    chk("rf_od0", 32'(out_data), 0);
    rst = 1'b0; ce = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rf_stale", 32'(out_valid), 0);
    end

    // random traffic against a scoreboard
    for (int n = 0; n < 4; n++) begin
      seq[n] = 8'(n * 64);
      wait_cnt[n] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ce = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      up_valid = 4'($urandom);
      for (int n = 0; n < 4; n++)
        up_data[n*DW +: DW] = seq[n];
      if (ce && out_valid && out_ready) out_pop();
      gpred = ce && (!out_valid || out_ready) &&
              (up_ready != 4'hF);
      fb = ~up_ready;
      for (int n = 0; n < 4; n++) begin
        if (ce && up_valid[n] && up_ready[n]) begin
          q[n].push_back(seq[n]);
          seq[n] = seq[n] + 8'd1;
        end
      end
      step();
      if (gpred) begin
        g = idx_of(out_data[11:8]);
        chk("sb_grant", 32'(out_valid), 1);
        for (int n = 0; n < 4; n++) begin
          if (fb[n]) begin
            if (n == g) wait_cnt[n] = 0;
            else begin
              wait_cnt[n]++;
              chk("sb_starve", 32'(wait_cnt[n] < 4), 1);
            end
          end
        end
      end
      for (int n = 0; n < 4; n++)
        if (!fb[n]) wait_cnt[n] = 0;
    end
    ce = 1'b1; out_ready = 1'b1; up_valid = '0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) out_pop();
      step();
    end
    chk("sb_idle", 32'(out_valid), 0);
    for (int n = 0; n < 4; n++)
      chk("sb_left", 32'(q[n].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
